// File: rtl/toa_tdc_pkg.sv
// Shared constants and types for the TOA fine-phase TDC self-test path.
package toa_tdc_pkg;

    localparam int unsigned NSTAGE      = 63;
    localparam logic [5:0]  POS_INVALID = 6'd63;
    localparam logic [6:0]  SWEEP_LAST  = 7'h7E;

    typedef enum logic [1:0] {
        MODE_IDLE       = 2'b00,
        MODE_SINGLE     = 2'b01,
        MODE_SWEEP      = 2'b10,
        MODE_SWEEP_CONT = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_PRESENT = 3'd2,
        ST_HOLD    = 3'd3,
        ST_NEXT    = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // Sweep successor; pos 63 has no ring pattern, so 0x3E steps straight to 0x40.
    function automatic logic [6:0] sweep_next(input logic [6:0] code);
        if (code == SWEEP_LAST) begin
            return 7'h00;
        end
        if (code[5:0] == POS_INVALID - 6'd1) begin
            return {1'b1, 6'd0};
        end
        return code + 7'd1;
    endfunction

endpackage

// File: rtl/toa_thermo_gen.sv
// Combinational fine code {h, pos} plus bubble count -> 63-stage ring sample word.
module toa_thermo_gen
    import toa_tdc_pkg::*;
(
    input  logic [6:0]        code,
    input  logic [1:0]        bubble,
    output logic [NSTAGE-1:0] word
);

    logic       h;
    logic [5:0] pos;
    logic [6:0] bsum;
    logic [5:0] bidx;

    assign h   = code[6];
    assign pos = code[5:0];

    always_comb begin
        word = '0;
        bsum = '0;
        bidx = '0;
        word[NSTAGE-1] = ~h;
        // Stages below pos carry one extra phase step, which creates the single equal pair.
        for (int i = 0; i < NSTAGE - 1; i++) begin
            word[i] = ~h ^ i[0] ^ (pos > 6'(i));
        end
        for (int k = 1; k <= 3; k++) begin
            if (2'(k) <= bubble) begin
                bsum = {1'b0, pos} + 7'(2 * k);
                bidx = (bsum >= 7'(NSTAGE)) ? 6'(bsum - 7'(NSTAGE)) : bsum[5:0];
                word[bidx] = ~word[bidx];
            end
        end
    end

endmodule

// File: rtl/toa_fine_pattern_gen.sv
// Fine-code pattern source: single/sweep sequencing, valid/ready handshake, hold spacing.
module toa_fine_pattern_gen
    import toa_tdc_pkg::*;
#(
    parameter int unsigned HOLD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic [6:0]        code_in,
    input  logic [1:0]        bubble,
    input  logic [HOLD_W-1:0] hold,
    input  logic              start,
    input  logic              pat_ready,
    output logic              pat_valid,
    output logic [NSTAGE-1:0] pat_word,
    output logic [6:0]        pat_code,
    output logic              busy,
    output logic              done,
    output logic              code_err
);

    state_e            state_q, state_d;
    mode_e             mode_q;
    logic [1:0]        bubble_q;
    logic [6:0]        code_q;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] cnt_q;
    logic              err_q;
    logic              valid_q;
    logic [NSTAGE-1:0] word_q;
    logic [6:0]        pcode_q;
    logic [NSTAGE-1:0] gen_word;
    logic              xfer;
    logic              bad_pos;

    toa_thermo_gen u_thermo (
        .code   (code_q),
        .bubble (bubble_q),
        .word   (gen_word)
    );

    assign xfer    = valid_q & pat_ready;
    assign bad_pos = (mode_q == MODE_SINGLE) && (code_q[5:0] == POS_INVALID);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start && (mode != MODE_IDLE)) state_d = ST_LOAD;
            ST_LOAD:    state_d = bad_pos ? ST_DONE : ST_PRESENT;
            ST_PRESENT: if (xfer) state_d = ST_HOLD;
            ST_HOLD:    if (cnt_q >= hold_q) state_d = ST_NEXT;
            ST_NEXT: begin
                if (mode_q == MODE_SINGLE) begin
                    state_d = ST_DONE;
                end else if ((mode_q == MODE_SWEEP) && (code_q == SWEEP_LAST)) begin
                    state_d = ST_DONE;
                end else if ((mode_q == MODE_SWEEP_CONT) && (mode == MODE_IDLE)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_IDLE;
            bubble_q <= '0;
            code_q   <= '0;
            hold_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            word_q   <= '0;
            pcode_q  <= '0;
        end else begin
            state_q <= state_d;
            // Valid rises one cycle into PRESENT, which keeps word/code a full cycle ahead of it.
            valid_q <= (state_q == ST_PRESENT) && !xfer;
            if ((state_q == ST_IDLE) && (state_d == ST_LOAD)) begin
                mode_q   <= mode_e'(mode);
                bubble_q <= bubble;
                code_q   <= (mode == MODE_SINGLE) ? code_in : 7'h00;
                err_q    <= 1'b0;
            end
            if (state_q == ST_LOAD) begin
                hold_q  <= hold;
                word_q  <= gen_word;
                pcode_q <= code_q;
                err_q   <= bad_pos;
            end
            if (state_q == ST_PRESENT) begin
                cnt_q <= HOLD_W'(1);
            end
            if (state_q == ST_HOLD) begin
                cnt_q <= cnt_q + HOLD_W'(1);
            end
            if (state_q == ST_NEXT) begin
                code_q <= sweep_next(code_q);
            end
        end
    end

    assign pat_valid = valid_q;
    assign pat_word  = word_q;
    assign pat_code  = pcode_q;
    assign busy      = (state_q == ST_LOAD) || (state_q == ST_PRESENT) ||
                       (state_q == ST_HOLD) || (state_q == ST_NEXT);
    assign done      = (state_q == ST_DONE);
    assign code_err  = done && err_q;

endmodule

// File: tb/tb_toa_fine_pattern_gen.sv
// Bench for toa_fine_pattern_gen: scenario tasks checked against a ring-word/decoder model.
module tb_toa_fine_pattern_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic [6:0]  code_in = 7'h00;
    logic [1:0]  bubble = 2'd0;
    logic [7:0]  hold = 8'd0;
    logic        start = 1'b0;
    logic        pat_ready = 1'b1;
    logic        pat_valid;
    logic [62:0] pat_word;
    logic [6:0]  pat_code;
    logic        busy;
    logic        done;
    logic        code_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    toa_fine_pattern_gen #(.HOLD_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .code_in   (code_in),
        .bubble    (bubble),
        .hold      (hold),
        .start     (start),
        .pat_ready (pat_ready),
        .pat_valid (pat_valid),
        .pat_word  (pat_word),
        .pat_code  (pat_code),
        .busy      (busy),
        .done      (done),
        .code_err  (code_err)
    );

    // Ring word from the code rule: bit i = ~h ^ ((i + 1 - (pos <= i)) mod 2), then bubble flips.
    function automatic logic [62:0] model_word(input logic [6:0] c, input int nb);
        logic [62:0] w;
        logic [5:0]  bi;
        int pos;
        int hb;
        pos = int'(c[5:0]);
        hb  = int'(c[6]);
        w = '0;
        w[62] = ~c[6];
        for (int i = 0; i < 62; i++) begin
            w[i] = 1'(((1 - hb) + i + 1 - ((pos <= i) ? 1 : 0)) % 2);
        end
        for (int k = 1; k <= nb; k++) begin
            bi = 6'((pos + 2 * k) % 63);
            w[bi] = ~w[bi];
        end
        return w;
    endfunction

    // Encoder view: locate the single equal adjacent pair around the ring; 7F if not unique.
    function automatic logic [6:0] decode(input logic [62:0] w);
        int hits;
        int p;
        hits = 0;
        p = 0;
        for (int i = 0; i < 63; i++) begin
            if (w[i] == w[(i + 62) % 63]) begin
                hits++;
                p = i;
            end
        end
        if (hits != 1) return 7'h7F;
        return {~w[62], 6'(p)};
    endfunction

    function automatic logic [6:0] sweep_code(input int idx);
        return (idx < 63) ? 7'(idx) : 7'(idx + 1);
    endfunction

    task automatic pulse_start(input logic [1:0] m, input logic [6:0] c, input logic [1:0] b,
                               input logic [7:0] h);
        @(negedge clk);
        mode = m;
        code_in = c;
        bubble = b;
        hold = h;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mode = 2'b11;
        start = 1'b1;
        hold = 8'd3;
        bubble = 2'd2;
        repeat (3) @(negedge clk);
        checks++;
        if ({pat_valid, busy, done, code_err} !== 4'b0 || pat_word !== '0 || pat_code !== '0) begin
            failures++;
            $display("FAIL reset: valid=%b busy=%b done=%b err=%b word=%h code=%h, want all 0",
                     pat_valid, busy, done, code_err, pat_word, pat_code);
        end
        start = 1'b0;
        mode = 2'b00;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || pat_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b valid=%b, want 0 0", busy, pat_valid);
        end
    endtask

    task automatic test_single(input logic [6:0] c, input logic [1:0] b, input logic [7:0] h,
                               input logic [62:0] exp_word, input string name);
        int hh;
        int n;
        pat_ready = 1'b1;
        pulse_start(2'b01, c, b, h);
        // Mode, code and bubble are captured at start; disturb them afterwards.
        bubble = ~b;
        code_in = ~c;
        mode = 2'b11;
        @(negedge clk);
        checks++;
        if (pat_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s latency_early: valid=%b busy=%b, want 0 1", name, pat_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (pat_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s latency: valid=%b, want 1", name, pat_valid);
        end
        checks++;
        if (pat_word !== exp_word || pat_code !== c) begin
            failures++;
            $display("FAIL %s word: word=%h code=%h, want word=%h code=%h",
                     name, pat_word, pat_code, exp_word, c);
        end
        hh = (h == 8'd0) ? 1 : int'(h);
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != hh + 2 || code_err !== 1'b0) begin
            failures++;
            $display("FAIL %s done_timing: cycles=%0d err=%b, want cycles=%0d err=0",
                     name, n, code_err, hh + 2);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || pat_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s after_done: done=%b busy=%b valid=%b, want 0 0 0",
                     name, done, busy, pat_valid);
        end
    endtask

    task automatic test_sweep_once();
        int n;
        int done_cnt;
        int tail;
        logic [6:0] e;
        pat_ready = 1'b1;
        pulse_start(2'b10, 7'($urandom), 2'd0, 8'd0);
        n = 0;
        done_cnt = 0;
        tail = 0;
        for (int cyc = 0; cyc < 3000 && tail < 6; cyc++) begin
            @(negedge clk);
            if (pat_valid && pat_ready) begin
                e = sweep_code(n);
                checks++;
                if (n >= 126 || pat_code !== e || pat_word !== model_word(e, 0) ||
                    decode(pat_word) !== pat_code) begin
                    failures++;
                    $display("FAIL sweep_xfer[%0d]: code=%h dec=%h word=%h, want code=%h word=%h",
                             n, pat_code, decode(pat_word), pat_word, e, model_word(e, 0));
                end
                n++;
            end
            if (done) done_cnt++;
            if (done_cnt > 0) tail++;
        end
        checks++;
        if (n != 126 || done_cnt != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL sweep_end: xfers=%0d done_pulses=%0d busy=%b, want 126 1 0",
                     n, done_cnt, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [6:0]  c;
        logic [62:0] ew;
        int nb;
        int n;
        bit found;
        bit seen;
        c = {1'($urandom), 6'($urandom_range(0, 62))};
        nb = $urandom_range(0, 3);
        pat_ready = 1'b0;
        pulse_start(2'b01, c, 2'(nb), 8'd2);
        found = 1'b0;
        for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            @(negedge clk);
            if (pat_valid) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL bp_valid: valid=%b, want 1 within 20 cycles", pat_valid);
        end
        ew = model_word(c, nb);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (pat_valid !== 1'b1 || pat_word !== ew || pat_code !== c) begin
                failures++;
                $display("FAIL bp_stable[%0d]: valid=%b word=%h code=%h, want 1 %h %h",
                         i, pat_valid, pat_word, pat_code, ew, c);
            end
        end
        pat_ready = 1'b1;
        n = (pat_valid && pat_ready) ? 1 : 0;
        @(negedge clk);
        checks++;
        if (pat_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: valid=%b, want 0", pat_valid);
        end
        seen = 1'b0;
        for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
            if (pat_valid && pat_ready) n++;
            if (done) seen = 1'b1;
            if (!seen) @(negedge clk);
        end
        checks++;
        if (n != 1 || !seen) begin
            failures++;
            $display("FAIL bp_count: xfers=%0d done_seen=%b, want 1 1", n, seen);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        logic [6:0] ca;
        logic [6:0] cb;
        int n;
        bit found;
        bit seen;
        bit bad;
        ca = {1'($urandom), 6'($urandom_range(0, 30))};
        cb = {~ca[6], 6'($urandom_range(31, 62))};
        pat_ready = 1'b0;
        pulse_start(2'b01, ca, 2'd0, 8'd1);
        found = 1'b0;
        for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            @(negedge clk);
            if (pat_valid) found = 1'b1;
        end
        pulse_start(2'b10, cb, 2'd3, 8'd0);
        checks++;
        if (!found || pat_valid !== 1'b1 || pat_code !== ca || pat_word !== model_word(ca, 0)) begin
            failures++;
            $display("FAIL busy_start: valid=%b code=%h word=%h, want 1 %h %h",
                     pat_valid, pat_code, pat_word, ca, model_word(ca, 0));
        end
        pat_ready = 1'b1;
        n = 0;
        bad = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
            if (pat_valid && pat_ready) begin
                n++;
                if (pat_code !== ca) bad = 1'b1;
            end
            if (done) seen = 1'b1;
            if (!seen) @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pat_valid || busy) bad = 1'b1;
        end
        checks++;
        if (n != 1 || !seen || bad) begin
            failures++;
            $display("FAIL busy_start_seq: xfers=%0d done_seen=%b restarted=%b, want 1 1 0",
                     n, seen, bad);
        end
        mode = 2'b00;
    endtask

    task automatic test_code_err();
        logic [6:0] c;
        c = {1'($urandom), 6'd63};
        pat_ready = 1'b1;
        pulse_start(2'b01, c, 2'($urandom), 8'd4);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL err_load: busy=%b done=%b, want 1 0", busy, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || code_err !== 1'b1 || pat_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL err_pulse: done=%b err=%b valid=%b busy=%b, want 1 1 0 0",
                     done, code_err, pat_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || code_err !== 1'b0 || pat_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL err_after: done=%b err=%b valid=%b busy=%b, want 0 0 0 0",
                     done, code_err, pat_valid, busy);
        end
    endtask

    task automatic test_sweep_cont();
        int n;
        int nb;
        bit seen;
        logic [6:0] e;
        nb = $urandom_range(0, 3);
        pat_ready = 1'b1;
        pulse_start(2'b11, 7'($urandom), 2'(nb), 8'd0);
        n = 0;
        for (int cyc = 0; cyc < 2000 && n < 130; cyc++) begin
            @(negedge clk);
            if (pat_valid && pat_ready) begin
                e = sweep_code(n % 126);
                checks++;
                if (pat_code !== e || pat_word !== model_word(e, nb)) begin
                    failures++;
                    $display("FAIL cont_xfer[%0d]: code=%h word=%h, want code=%h word=%h",
                             n, pat_code, pat_word, e, model_word(e, nb));
                end
                n++;
            end
        end
        checks++;
        if (n != 130) begin
            failures++;
            $display("FAIL cont_count: xfers=%0d, want 130", n);
        end
        mode = 2'b00;
        seen = 1'b0;
        for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (!seen || busy !== 1'b0 || pat_valid !== 1'b0) begin
            failures++;
            $display("FAIL cont_stop: done_seen=%b busy=%b valid=%b, want 1 0 0",
                     seen, busy, pat_valid);
        end
    endtask

    task automatic test_reset_mid_sweep();
        bit found;
        bit seen;
        pat_ready = 1'b1;
        pulse_start(2'b11, 7'h00, 2'd0, 8'($urandom_range(0, 2)));
        found = 1'b0;
        for (int cyc = 0; cyc < 3000 && !found; cyc++) begin
            @(negedge clk);
            if (pat_valid && pat_code === 7'h25) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rst_reach: code=%h, want 25 within budget", pat_code);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({pat_valid, busy, done, code_err} !== 4'b0 || pat_word !== '0 || pat_code !== '0) begin
            failures++;
            $display("FAIL rst_mid: valid=%b busy=%b done=%b err=%b word=%h code=%h, want all 0",
                     pat_valid, busy, done, code_err, pat_word, pat_code);
        end
        reset = 1'b0;
        mode = 2'b00;
        pulse_start(2'b11, 7'h55, 2'd0, 8'd0);
        found = 1'b0;
        for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            @(negedge clk);
            if (pat_valid) found = 1'b1;
        end
        checks++;
        if (!found || pat_code !== 7'h00 || pat_word !== model_word(7'h00, 0)) begin
            failures++;
            $display("FAIL rst_restart: valid=%b code=%h word=%h, want 1 00 %h",
                     pat_valid, pat_code, pat_word, model_word(7'h00, 0));
        end
        mode = 2'b00;
        seen = 1'b0;
        for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rst_stop: done=%b, want pulse within 50 cycles", done);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [6:0] c;
        logic [1:0] b;
        logic [7:0] h;
        test_reset();
        test_single(7'h40, 2'd0, 8'd0, 63'h2AAA_AAAA_AAAA_AAAA, "single_40");
        test_single(7'h40, 2'd1, 8'd1, 63'h2AAA_AAAA_AAAA_AAAE, "single_40_b1");
        test_single(7'h3E, 2'd0, 8'd3, 63'h6AAA_AAAA_AAAA_AAAA, "single_3e");
        for (int i = 0; i < 6; i++) begin
            c = {1'($urandom), 6'($urandom_range(0, 62))};
            b = 2'($urandom);
            h = 8'($urandom_range(0, 6));
            test_single(c, b, h, model_word(c, int'(b)), "single_rand");
        end
        test_sweep_once();
        test_backpressure();
        test_start_ignored();
        test_code_err();
        test_sweep_cont();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
